// File: rtl/conv_encoder_packetizer.sv
// Byte FIFO feeding a rate-1/2, K=3 convolutional encoder (g1=7, g2=5, MSB first).
// Each byte becomes one 16-bit packet, held in SEND until the downstream decoder is not busy.
module conv_encoder_packetizer #(
    parameter int DEPTH      = 4,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dvalid_i,
    input  logic [7:0]  data_i,
    output logic        busy_o,
    output logic        ovf_o,
    input  logic        down_busy_i,
    output logic        dvalid_o,
    output logic [15:0] data_o,
    output logic        idle_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    sh;
    logic [2:0]    idx;
    logic [1:0]    s;
    logic [15:0]   pkt;
    logic          push;
    logic          pop;
    logic          b;
    logic          g1;
    logic          g2;

    // Full and push decisions use the pre-edge count, so a write while full is dropped
    // even if the FSM pops on the same edge.
    assign busy_o = (count == (AW+1)'(DEPTH));
    assign push   = dvalid_i & ~busy_o;
    assign pop    = (state == IDLE) && (count != '0);
    assign idle_o = (count == '0) && (state == IDLE);

    assign b  = sh[idx];
    assign g1 = b ^ s[1] ^ s[0];
    assign g2 = b ^ s[0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (dvalid_i && busy_o) begin
                ovf_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sh       <= '0;
            idx      <= '0;
            s        <= 2'b00;
            pkt      <= '0;
            dvalid_o <= 1'b0;
            data_o   <= '0;
        end else begin
            dvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        sh    <= mem[rd_ptr];
                        idx   <= 3'd7;
                        state <= ENC;
                        if (CONTINUOUS == 1'b0) begin
                            s <= 2'b00;
                        end
                    end
                end
                ENC: begin
                    // Code pair for bit idx lands at pkt[2*idx+1 : 2*idx], g1 in the upper bit.
                    pkt[{idx, 1'b1}] <= g1;
                    pkt[{idx, 1'b0}] <= g2;
                    s                <= {b, s[1]};
                    idx              <= idx - 3'd1;
                    if (idx == 3'd0) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (!down_busy_i) begin
                        data_o   <= pkt;
                        dvalid_o <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_packetizer.sv
// Bench for conv_encoder_packetizer: directed byte vectors with known packets, a scoreboard
// queue per instance (CONTINUOUS=0 and CONTINUOUS=1) and a negedge monitor popping on dvalid_o.
module tb_conv_encoder_packetizer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dvalid_i;
  logic [7:0]  data_i;
  logic        busy_o;
  logic        ovf_o;
  logic        down_busy_i;
  logic        dvalid_o;
  logic [15:0] data_o;
  logic        idle_o;

  logic        c_dvalid_i;
  logic [7:0]  c_data_i;
  logic        c_busy_o;
  logic        c_ovf_o;
  logic        c_down_busy_i;
  logic        c_dvalid_o;
  logic [15:0] c_data_o;
  logic        c_idle_o;

  int checks = 0;
  int failures = 0;
  int neg_cnt = 0;
  int pulse_cnt = 0;
  int last_pulse_neg = -1;
  int c_pulse_cnt = 0;
  logic prev_dv = 1'b0;
  logic busy_seen = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_c_q[$];

  conv_encoder_packetizer #(.DEPTH(DEPTH), .CONTINUOUS(1'b0)) u_dut (
    .clk(clk), .rst(rst), .dvalid_i(dvalid_i), .data_i(data_i), .busy_o(busy_o),
    .ovf_o(ovf_o), .down_busy_i(down_busy_i), .dvalid_o(dvalid_o), .data_o(data_o),
    .idle_o(idle_o)
  );

  conv_encoder_packetizer #(.DEPTH(DEPTH), .CONTINUOUS(1'b1)) u_cont (
    .clk(clk), .rst(rst), .dvalid_i(c_dvalid_i), .data_i(c_data_i), .busy_o(c_busy_o),
    .ovf_o(c_ovf_o), .down_busy_i(c_down_busy_i), .dvalid_o(c_dvalid_o), .data_o(c_data_o),
    .idle_o(c_idle_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference encoder: returns {final_state, packet}
  function automatic logic [17:0] enc(input logic [7:0] byte_in, input logic [1:0] s_in);
    logic [1:0]  st;
    logic [15:0] p;
    logic        bv;
    st = s_in;
    p = '0;
    for (int k = 7; k >= 0; k--) begin
      bv = byte_in[k];
      p[2*k+1] = bv ^ st[1] ^ st[0];
      p[2*k] = bv ^ st[0];
      st = {bv, st[1]};
    end
    return {st, p};
  endfunction

  // monitor for the CONTINUOUS=0 instance
  always @(negedge clk) begin
    logic [15:0] e;
    neg_cnt++;
    if (dvalid_o) begin
      pulse_cnt++;
      last_pulse_neg = neg_cnt;
      checks++;
      if (busy_seen) begin
        failures++;
        $display("FAIL emit_while_busy: got dvalid_o=1 with down_busy_i=1 at prior edge, required no emission");
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pkt: got data_o=%h, required no packet", data_o);
      end else begin
        e = exp_q.pop_front();
        if (data_o !== e) begin
          failures++;
          $display("FAIL pkt: got data_o=%h, required %h", data_o, e);
        end
      end
      checks++;
      if (prev_dv) begin
        failures++;
        $display("FAIL pulse_width: got dvalid_o high 2 cycles, required 1");
      end
    end
    prev_dv = dvalid_o;
    busy_seen = down_busy_i;
  end

  // monitor for the CONTINUOUS=1 instance
  always @(negedge clk) begin
    logic [15:0] e;
    if (c_dvalid_o) begin
      c_pulse_cnt++;
      checks++;
      if (exp_c_q.size() == 0) begin
        failures++;
        $display("FAIL c_unexpected_pkt: got data_o=%h, required no packet", c_data_o);
      end else begin
        e = exp_c_q.pop_front();
        if (c_data_o !== e) begin
          failures++;
          $display("FAIL c_pkt: got data_o=%h, required %h", c_data_o, e);
        end
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic write_byte(input logic [7:0] b);
    dvalid_i = 1'b1;
    data_i = b;
    cyc();
    dvalid_i = 1'b0;
  endtask

  task automatic c_write_byte(input logic [7:0] b);
    c_dvalid_i = 1'b1;
    c_data_i = b;
    cyc();
    c_dvalid_i = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] b);
    logic [17:0] r;
    r = enc(b, 2'b00);
    exp_q.push_back(r[15:0]);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_c_q.size() != 0 || !idle_o || !c_idle_o) && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout: got %0d packets still expected after %0d cycles, required 0",
               name, exp_q.size() + exp_c_q.size(), budget);
    end
    cyc();
  endtask

  initial begin
    int w_neg;
    int rel_neg;
    int p0;
    rst = 1'b1;
    dvalid_i = 1'b0;
    data_i = '0;
    down_busy_i = 1'b0;
    c_dvalid_i = 1'b0;
    c_data_i = '0;
    c_down_busy_i = 1'b0;
    cycles(3);
    chk("rst_dvalid", 16'(dvalid_o), 16'h0);
    chk("rst_data", data_o, 16'h0000);
    chk("rst_ovf", 16'(ovf_o), 16'h0);
    chk("rst_busy", 16'(busy_o), 16'h0);
    chk("rst_idle", 16'(idle_o), 16'h1);
    rst = 1'b0;
    cyc();

    // single byte, latency and idle return
    p0 = pulse_cnt;
    exp_q.push_back(16'h00DA);
    write_byte(8'h0F);
    w_neg = neg_cnt + 1;
    chk("busy_idle_low", 16'(idle_o), 16'h0);
    wait_drain("t1", 40);
    chk("latency", 16'(last_pulse_neg - w_neg), 16'd10);
    chk("t1_pulses", 16'(pulse_cnt - p0), 16'd1);
    chk("t1_idle", 16'(idle_o), 16'h1);
    chk("t1_ovf", 16'(ovf_o), 16'h0);

    // back-to-back bytes, encoder state cleared per packet
    exp_q.push_back(16'hE2F8);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h00DA);
    write_byte(8'hA5);
    write_byte(8'h00);
    write_byte(8'h0F);
    wait_drain("t2", 100);

    // downstream busy holds the packet in SEND
    p0 = pulse_cnt;
    down_busy_i = 1'b1;
    exp_q.push_back(16'hE2F8);
    write_byte(8'hA5);
    cycles(20);
    chk("held_no_pulse", 16'(pulse_cnt - p0), 16'd0);
    down_busy_i = 1'b0;
    rel_neg = neg_cnt + 2;
    wait_drain("t3", 40);
    chk("release_timing", 16'(last_pulse_neg), 16'(rel_neg));
    chk("t3_pulses", 16'(pulse_cnt - p0), 16'd1);

    // overflow: DEPTH+2 writes while blocked, DEPTH+1 survive
    p0 = pulse_cnt;
    down_busy_i = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (k < DEPTH + 1) push_exp(8'(8'h11 * (k + 1)));
      write_byte(8'(8'h11 * (k + 1)));
    end
    chk("full_busy", 16'(busy_o), 16'h1);
    chk("ovf_set", 16'(ovf_o), 16'h1);
    cycles(15);
    chk("ovf_no_pulse", 16'(pulse_cnt - p0), 16'd0);
    down_busy_i = 1'b0;
    wait_drain("t4", 200);
    chk("ovf_pulses", 16'(pulse_cnt - p0), 16'(DEPTH + 1));
    chk("ovf_sticky", 16'(ovf_o), 16'h1);

    // reset during ENC aborts the byte
    p0 = pulse_cnt;
    write_byte(8'hFF);
    cycles(4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_data", data_o, 16'h0000);
    chk("abort_idle", 16'(idle_o), 16'h1);
    chk("abort_ovf", 16'(ovf_o), 16'h0);
    chk("abort_busy", 16'(busy_o), 16'h0);
    cycles(20);
    chk("abort_no_pulse", 16'(pulse_cnt - p0), 16'd0);
    exp_q.push_back(16'h00DA);
    write_byte(8'h0F);
    wait_drain("t5", 40);

    // random bytes with random downstream backpressure
    p0 = pulse_cnt;
    for (int k = 0; k < 300; k++) begin
      logic [7:0] rb;
      down_busy_i = ($urandom_range(0, 3) == 0);
      if (!busy_o && $urandom_range(0, 3) == 0) begin
        rb = 8'($urandom_range(0, 255));
        push_exp(rb);
        write_byte(rb);
      end else begin
        cyc();
      end
    end
    down_busy_i = 1'b0;
    wait_drain("t6", 2000);
    chk("rand_ovf", 16'(ovf_o), 16'h0);

    // CONTINUOUS=1: encoder state carried across packets
    exp_c_q.push_back(16'hE2F8);
    exp_c_q.push_back(16'hB000);
    exp_c_q.push_back(16'h00DA);
    c_write_byte(8'hA5);
    c_write_byte(8'h00);
    c_write_byte(8'h0F);
    wait_drain("t7", 100);
    chk("cont_pulses", 16'(c_pulse_cnt), 16'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_encoder_packetizer.md
Name: conv_encoder_packetizer

Overview:
Upstream stimulus/transmit stage for the Viterbi decoder system. It accepts 8-bit payload bytes and encodes them with the rate-1/2, K=3 convolutional code (g1=7 octal, g2=5 octal), one bit per cycle, MSB first. It emits 16-bit coded packets on the decoder's dvalid_i/data_i interface and honours the decoder's busy_o backpressure. A small byte FIFO decouples the byte source from encoding and backpressure.

Parameters:
DEPTH, 4, input byte FIFO depth in entries; power of 2, 2..16.
CONTINUOUS, 0, 0 = encoder state cleared to 2'b00 at the start of every packet; 1 = state carried across packets, cleared only by reset.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  asynchronous reset, active-high; one clock domain only.
dvalid_i  input  1  byte write strobe from the source.
data_i  input  8  payload byte; sampled when dvalid_i=1.
busy_o  output  1  FIFO full; combinational from the occupancy count.
ovf_o  output  1  sticky flag: a write was attempted while full.
down_busy_i  input  1  decoder busy_o; blocks packet emission while high.
dvalid_o  output  1  one-cycle strobe; data_o holds a new packet (connects to decoder dvalid_i).
data_o  output  16  coded packet (connects to decoder data_i).
idle_o  output  1  high when the FIFO is empty, the FSM is IDLE and no packet is pending.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO pointers and count = 0; FSM = IDLE; encoder state s = 2'b00.
  - dvalid_o = 0, data_o = 16'h0000, ovf_o = 0, busy_o = 0, idle_o = 1.
  - Any in-flight byte or packet is discarded.
- Write side:
  - A byte is pushed on a rising edge with dvalid_i=1 and count<DEPTH.
  - A write while full is dropped and sets ovf_o. This holds even if a pop occurs on the same edge; the full check uses the pre-edge count.
  - A simultaneous push and pop (when not full) leaves count unchanged.
- FSM IDLE: if the FIFO is non-empty, pop the head into shift register sh[7:0] and go to ENC with bit index i=7.
  - If CONTINUOUS=0, s is cleared to 00 at the pop.
- FSM ENC: each cycle takes b = sh[i], then:
  - g1 = b^s[1]^s[0]; g2 = b^s[0].
  - pkt[2i+1] = g1; pkt[2i] = g2.
  - s <= {b, s[1]}.
  - After i=0, go to SEND. ENC lasts exactly 8 cycles.
- FSM SEND:
  - If down_busy_i=0 on an edge, register data_o <= pkt, pulse dvalid_o high for exactly one cycle, and go to IDLE.
  - Otherwise hold in SEND indefinitely. pkt is unchanged and dvalid_o stays 0.
- data_o holds its last value after dvalid_o deasserts, until the next emission.
- Latency (down_busy_i=0):
  - Byte written at edge E0; pop at E1; ENC at E2..E9; data_o/dvalid_o update at E10.
  - dvalid_o is high during the cycle after E10, i.e. 10 cycles of latency.
- Throughput: at most one packet every 10 cycles. The next pop occurs the edge after the SEND edge.
- The FIFO continues to accept bytes during ENC and SEND.
- The pop occurs only in IDLE.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Reset asserted during ENC or SEND: the FSM returns to IDLE immediately. No dvalid_o pulse occurs for the aborted byte.

Test Plan:
- Reset, write 8'h0F, down_busy_i=0 -> single dvalid_o pulse 10 cycles after the write, data_o=16'h00DA; idle_o returns to 1.
- Write 8'hA5 -> data_o=16'hE2F8. With CONTINUOUS=0, a following 8'h00 -> 16'h0000. With CONTINUOUS=1, the same 8'h00 after 8'hA5 -> 16'hB000.
- Write 8'hA5 with down_busy_i held high for 20 cycles -> no dvalid_o while high. Emission occurs on the first edge with down_busy_i=0, data_o=16'hE2F8, exactly one pulse.
- Hold down_busy_i=1 and write DEPTH+2 bytes back-to-back -> busy_o=1 after the FIFO fills, extra writes dropped, ovf_o=1. Release -> exactly DEPTH+1 packets in write order (one byte already in SEND plus DEPTH queued).
- Assert rst for 1 cycle during ENC of 8'hFF -> dvalid_o never pulses for it, data_o=0, FIFO empty. A subsequent write of 8'h0F -> 16'h00DA.
- Random bytes against a reference model of the encode equations; continuous stream with random down_busy_i -> every packet matches, order preserved, no dvalid_o pulse while down_busy_i=1.
